// File: rtl/seg_scan_mux.sv
// Four-digit common-anode hex scanner: shows a 16-bit frame value with leading-zero
// blanking, per-digit decimal points and an all-off gap between digits.
module seg_scan_mux #(
    parameter int PRESCALE   = 50000,
    parameter int GAP_CYCLES = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] value_in,
    input  logic        load,
    input  logic [3:0]  dp_in,
    input  logic        lz_blank,
    output logic [3:0]  ledSync,
    output logic [7:0]  ledOut,
    output logic        fsm_state
);

    // load is a single-cycle strobe with no back-pressure: value_in is taken on
    // every rising edge where load=1 and reset=0; there is no ready signal.

    typedef enum logic {SHOW = 1'b0, GAP = 1'b1} state_t;

    localparam int MAXC = (PRESCALE > GAP_CYCLES) ? PRESCALE : GAP_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] P_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] G_LAST = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    digit, digit_n;
    logic [15:0]   shadow, disp, disp_n;
    logic          advance, blank;
    logic [3:0]    nib;
    logic [6:0]    seg;
    logic [3:0]    sync_n;
    logic [7:0]    out_n;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        advance = 1'b0;
        case (state)
            SHOW: begin
                if (cnt == P_LAST) begin
                    cnt_n = '0;
                    if (GAP_CYCLES > 0) state_n = GAP;
                    else                advance = 1'b1;
                end
            end
            default: begin
                if (cnt == G_LAST) begin
                    cnt_n   = '0;
                    advance = 1'b1;
                    state_n = SHOW;
                end
            end
        endcase
        digit_n = advance ? digit + 2'd1 : digit;

        // Frame boundary: a load in this very cycle bypasses the shadow register.
        disp_n = disp;
        if (advance && digit == 2'd3) disp_n = load ? value_in : shadow;

        // Outputs are computed from next-state values so they change on the entry edge.
        nib = disp_n[digit_n*4 +: 4];
        case (digit_n)
            2'd3:    blank = lz_blank && (disp_n[15:12] == 4'h0);
            2'd2:    blank = lz_blank && (disp_n[15:8]  == 8'h00);
            2'd1:    blank = lz_blank && (disp_n[15:4]  == 12'h000);
            default: blank = 1'b0;
        endcase
        seg = blank ? 7'h7F : hex7(nib);

        sync_n = 4'hF;
        out_n  = 8'hFF;
        if (state_n == SHOW) begin
            sync_n = ~(4'b0001 << digit_n);
            out_n  = {~dp_in[digit_n], seg};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= SHOW;
            cnt     <= '0;
            digit   <= 2'd0;
            shadow  <= 16'h0000;
            disp    <= 16'h0000;
            ledSync <= 4'hF;
            ledOut  <= 8'hFF;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            digit   <= digit_n;
            disp    <= disp_n;
            ledSync <= sync_n;
            ledOut  <= out_n;
            if (load) shadow <= value_in;
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with PRESCALE=4, GAP_CYCLES=1 (20-cycle frame).
// k counts posedges since reset release; frame f digit d is lit at k=20f+5d..+3, gap at +4.
module tb_seg_scan_mux;

    localparam int PRESCALE   = 4;
    localparam int GAP_CYCLES = 1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value_in = 16'h0000;
    logic        load = 1'b0;
    logic [3:0]  dp_in = 4'h0;
    logic        lz_blank = 1'b0;
    logic [3:0]  ledSync;
    logic [7:0]  ledOut;
    logic        fsm_state;

    int n_cmp = 0;
    int n_fail = 0;
    int k = 0;

    logic [7:0] hex_tab [0:15] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                   8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    seg_scan_mux #(.PRESCALE(PRESCALE), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clock(clock), .reset(reset), .value_in(value_in), .load(load),
        .dp_in(dp_in), .lz_blank(lz_blank), .ledSync(ledSync), .ledOut(ledOut),
        .fsm_state(fsm_state)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
        k++;
    endtask

    task automatic run_to(input int target);
        while (k < target) tick();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        load  = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        k = 0;
    endtask

    task automatic test_reset();
        do_reset();
        value_in = 16'hABCD; load = 1'b1; tick(); load = 1'b0;
        run_to(25);
        n_cmp++;
        if (ledSync !== 4'b1101 || ledOut !== 8'hC6) begin
            n_fail++;
            $display("FAIL pre_reset: got %b/%h expected 1101/c6", ledSync, ledOut);
        end
        reset = 1'b1; value_in = 16'h1111; load = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            load = 1'b0;
            n_cmp++;
            if (ledSync !== 4'hF || ledOut !== 8'hFF) begin
                n_fail++;
                $display("FAIL reset_out: cyc %0d got %b/%h expected 1111/ff", i, ledSync, ledOut);
            end
        end
        reset = 1'b0; k = 0;
        tick();
        n_cmp++;
        if (ledSync !== 4'b1110 || ledOut !== 8'hC0) begin
            n_fail++;
            $display("FAIL post_reset: got %b/%h expected 1110/c0", ledSync, ledOut);
        end
        n_cmp++;
        if (dut.shadow !== 16'h0000 || dut.disp !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_regs: got shadow=%h disp=%h expected 0000/0000", dut.shadow, dut.disp);
        end
    endtask

    task automatic test_timing();
        logic [15:0] v;
        logic [3:0]  es;
        logic [7:0]  eo;
        int d, pos;
        v = 16'h1234;
        do_reset();
        value_in = v; load = 1'b1; tick(); load = 1'b0;
        for (int c = 20; c < 40; c++) begin
            run_to(c);
            d = (c - 20) / 5;
            pos = (c - 20) % 5;
            if (pos == 4) begin
                es = 4'hF; eo = 8'hFF;
            end else begin
                es = ~(4'b0001 << d); eo = hex_tab[v[d*4 +: 4]];
            end
            n_cmp++;
            if (ledSync !== es || ledOut !== eo) begin
                n_fail++;
                $display("FAIL timing: k=%0d got %b/%h expected %b/%h", c, ledSync, ledOut, es, eo);
            end
        end
    endtask

    task automatic test_tear_free();
        int         ks [6] = '{50, 55, 60, 65, 70, 75};
        logic [3:0] ss [6] = '{4'b1011, 4'b0111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [7:0] os [6] = '{8'hA4, 8'hF9, 8'h88, 8'hC0, 8'h8E, 8'h80};
        run_to(45);
        value_in = 16'h8F0A; load = 1'b1; tick(); load = 1'b0;
        for (int i = 0; i < 6; i++) begin
            run_to(ks[i]);
            n_cmp++;
            if (ledSync !== ss[i] || ledOut !== os[i]) begin
                n_fail++;
                $display("FAIL tear_free: k=%0d got %b/%h expected %b/%h", ks[i], ledSync, ledOut, ss[i], os[i]);
            end
        end
    endtask

    task automatic test_boundary_bypass();
        int         ks [3] = '{80, 85, 95};
        logic [3:0] ss [3] = '{4'b1110, 4'b1101, 4'b0111};
        logic [7:0] os [3] = '{8'h92, 8'h86, 8'hC0};
        run_to(79);
        value_in = 16'h00E5; load = 1'b1; tick(); load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run_to(ks[i]);
            n_cmp++;
            if (ledSync !== ss[i] || ledOut !== os[i]) begin
                n_fail++;
                $display("FAIL bypass: k=%0d got %b/%h expected %b/%h", ks[i], ledSync, ledOut, ss[i], os[i]);
            end
        end
    endtask

    task automatic test_blanking();
        int         ks [11] = '{100, 105, 110, 115, 120, 125, 130, 135, 145, 150, 155};
        logic [7:0] os [11] = '{8'hC0, 8'h92, 8'hFF, 8'hFF, 8'hC0, 8'hFF, 8'hFF, 8'hFF,
                                8'h92, 8'hC0, 8'hC0};
        logic [3:0] es;
        run_to(96);
        lz_blank = 1'b1; value_in = 16'h0050; load = 1'b1; tick(); load = 1'b0;
        for (int i = 0; i < 11; i++) begin
            if (ks[i] == 145) begin
                run_to(138);
                lz_blank = 1'b0; value_in = 16'h0050; load = 1'b1; tick(); load = 1'b0;
            end
            if (ks[i] == 120) begin
                run_to(116);
                value_in = 16'h0000; load = 1'b1; tick(); load = 1'b0;
            end
            run_to(ks[i]);
            es = ~(4'b0001 << ((ks[i] % 20) / 5));
            n_cmp++;
            if (ledSync !== es || ledOut !== os[i]) begin
                n_fail++;
                $display("FAIL blanking: k=%0d got %b/%h expected %b/%h", ks[i], ledSync, ledOut, es, os[i]);
            end
        end
    endtask

    task automatic test_dp();
        logic [7:0] os [4] = '{8'hF8, 8'hFF, 8'h7F, 8'hFF};
        logic [3:0] es;
        run_to(158);
        dp_in = 4'b0100; lz_blank = 1'b1; value_in = 16'h0007; load = 1'b1; tick(); load = 1'b0;
        for (int d = 0; d < 4; d++) begin
            run_to(160 + 5 * d);
            es = ~(4'b0001 << d);
            n_cmp++;
            if (ledSync !== es || ledOut !== os[d] || fsm_state !== 1'b0) begin
                n_fail++;
                $display("FAIL dp_digit: d=%0d got %b/%h st=%b expected %b/%h st=0",
                         d, ledSync, ledOut, fsm_state, es, os[d]);
            end
            run_to(164 + 5 * d);
            n_cmp++;
            if (ledSync !== 4'hF || ledOut !== 8'hFF || fsm_state !== 1'b1) begin
                n_fail++;
                $display("FAIL dp_gap: d=%0d got %b/%h st=%b expected 1111/ff st=1",
                         d, ledSync, ledOut, fsm_state);
            end
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_tear_free();
        test_boundary_bypass();
        test_blanking();
        test_dp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
